// File: rtl/pattern_fifo_reader_if.sv
// pattern_fifo_reader_if: FIFO read port plus imager pattern bus of the pattern FIFO reader.
interface pattern_fifo_reader_if;
  logic        FIFO_empty;
  logic [9:0]  FIFO_dout;
  logic        FIFO_rd;
  logic [9:0]  Pat_out;
  logic        Pat_valid;
  logic        Row_latch;
  logic [7:0]  Row_addr;
  logic        Subc_done;
  logic [31:0] CntSubc;
  logic        Underflow;
  modport master (
    input  FIFO_empty, FIFO_dout,
    output FIFO_rd, Pat_out, Pat_valid, Row_latch, Row_addr, Subc_done, CntSubc, Underflow
  );
  modport slave (
    output FIFO_empty, FIFO_dout,
    input  FIFO_rd, Pat_out, Pat_valid, Row_latch, Row_addr, Subc_done, CntSubc, Underflow
  );
endinterface

// File: rtl/pattern_fifo_reader.sv
// pattern_fifo_reader: pops mask words from the pattern FIFO, groups them into rows,
// pulses a row latch per row and counts rows/subframes, flagging mid-row underflow.
module pattern_fifo_reader #(
  parameter int C_NUM_ROWS      = 160,
  parameter int C_WORDS_PER_ROW = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear_err,
  pattern_fifo_reader_if.master bus
);
  localparam int CW = $clog2(C_WORDS_PER_ROW + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;
  localparam logic [CW-1:0] WORDS     = CW'(C_WORDS_PER_ROW);
  localparam logic [CW-1:0] LAST_WORD = CW'(C_WORDS_PER_ROW - 1);
  localparam logic [7:0]    LAST_ROW  = 8'(C_NUM_ROWS - 1);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]    row_q, row_d;
  logic [31:0]   subc_q, subc_d;
  logic          uf_q, uf_d;
  logic          pv_q, pv_d;
  logic [9:0]    pat_q, pat_d;
  logic          rd, latch, last_row;
  logic [9:0]    pat_out;
  always_comb begin
    rd       = state_q == S_READ && !bus.FIFO_empty && rd_cnt_q < WORDS;
    latch    = state_q == S_LATCH;
    last_row = row_q == LAST_ROW;
    // FIFO data lands the cycle after the pop, so the bus passes it through while valid and then holds it
    pat_out  = pv_q ? bus.FIFO_dout : pat_q;
    pat_d    = pat_out;
    pv_d     = rd;
    rd_cnt_d = latch ? '0 : rd_cnt_q + CW'(rd);
    row_d    = latch ? (last_row ? 8'd0 : row_q + 8'd1) : row_q;
    subc_d   = subc_q + 32'(latch && last_row);
    uf_d     = (state_q == S_READ && bus.FIFO_empty && rd_cnt_q != '0) || (uf_q && !clear_err);
    state_d  = state_q == S_IDLE  ? (enable ? S_READ : S_IDLE) :
               state_q == S_READ  ? (rd && rd_cnt_q == LAST_WORD ? S_DRAIN : S_READ) :
               state_q == S_DRAIN ? S_LATCH :
               (!last_row || enable) ? S_READ : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      row_q    <= '0;
      subc_q   <= '0;
      uf_q     <= 1'b0;
      pv_q     <= 1'b0;
      pat_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      row_q    <= row_d;
      subc_q   <= subc_d;
      uf_q     <= uf_d;
      pv_q     <= pv_d;
      pat_q    <= pat_d;
    end
  end
  assign bus.FIFO_rd   = rd;
  assign bus.Pat_out   = pat_out;
  assign bus.Pat_valid = pv_q;
  assign bus.Row_latch = latch;
  assign bus.Row_addr  = row_q;
  assign bus.Subc_done = latch && last_row;
  assign bus.CntSubc   = subc_q;
  assign bus.Underflow = uf_q;
endmodule
